// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor tile: LSB-first A/B streams on ui_in, D = A - B streamed on uo_out[0], frame
// result byte on uio_out. Optional SUB_ADD_MODE_EN: uio_in[0] picks add (1) or subtract (0) per frame.
module tt_um_serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic a_bit;
    logic b_bit;
    logic beat;
    logic last_bit;

    assign a_bit    = ui_in[0];
    assign b_bit    = ui_in[1];
    assign beat     = ui_in[2] & ena;
    assign last_bit = ui_in[3];

    // Frame accumulation state
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] part_reg;
    logic             ovf_acc_reg;

    // Registered outputs
    logic             diff_reg;
    logic             valid_out_reg;
    logic             last_out_reg;
    logic             borrow_reg;
    logic             zero_reg;
    logic             ovf_reg;
    logic [1:0]       frame_cnt_reg;
    logic [WIDTH-1:0] result_reg;

    logic             frame_start;
    logic             add_mode;
    logic             d_bit;
    logic             br_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] part_next;

    assign frame_start = (cnt_reg == '0);

`ifdef SUB_ADD_MODE_EN
    logic mode_reg;
    logic unused_inputs;

    // The mode bit is taken live on the first beat so that beat already uses it.
    assign add_mode      = frame_start ? uio_in[0] : mode_reg;
    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in[7:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
        end else if (beat && frame_start) begin
            mode_reg <= uio_in[0];
        end
    end
`else
    logic unused_inputs;

    assign add_mode      = 1'b0;
    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};
`endif

    assign d_bit = a_bit ^ b_bit ^ br_reg;

    always_comb begin
        br_next = 1'b0;
        if (add_mode) begin
            br_next = (a_bit & b_bit) | (br_reg & (a_bit ^ b_bit));
        end else begin
            br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
        end
    end

    assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign ovf_next = ovf_acc_reg | (cnt_reg == CNT_MAX);

    // Per-bit capture: the beat index selects the bit; a new frame wipes the stale upper bits.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_part
            always_comb begin
                part_next[gi] = part_reg[gi];
                if (cnt_reg == CNT_W'(gi)) begin
                    part_next[gi] = d_bit;
                end else if (frame_start) begin
                    part_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_reg        <= 1'b0;
            cnt_reg       <= '0;
            part_reg      <= '0;
            ovf_acc_reg   <= 1'b0;
            diff_reg      <= 1'b0;
            valid_out_reg <= 1'b0;
            last_out_reg  <= 1'b0;
            borrow_reg    <= 1'b0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            frame_cnt_reg <= 2'd0;
            result_reg    <= '0;
        end else begin
            diff_reg      <= beat & d_bit;
            valid_out_reg <= beat;
            last_out_reg  <= beat & last_bit;
            if (beat) begin
                part_reg <= part_next;
                if (last_bit) begin
                    result_reg    <= part_next;
                    borrow_reg    <= br_next;
                    zero_reg      <= (part_next == '0);
                    ovf_reg       <= ovf_next;
                    frame_cnt_reg <= frame_cnt_reg + 2'd1;
                    br_reg        <= 1'b0;
                    cnt_reg       <= '0;
                    ovf_acc_reg   <= 1'b0;
                end else begin
                    br_reg      <= br_next;
                    cnt_reg     <= cnt_next;
                    ovf_acc_reg <= ovf_next;
                end
            end
        end
    end

    assign uo_out  = {frame_cnt_reg, ovf_reg, zero_reg, last_out_reg,
                      valid_out_reg, borrow_reg, diff_reg};
    assign uio_out = 8'(result_reg);
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Scoreboard bench for tt_um_serial_subtractor: frames built from integer operands, expected
// stream and frame results computed with plain arithmetic, checked by an independent monitor.
module tb_tt_um_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_serial_subtractor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    typedef struct packed {
        logic d;
        logic last;
    } beat_t;

    typedef struct packed {
        logic [7:0] res;
        logic       flag;
        logic       zero;
        logic       ovf;
        logic [1:0] fcnt;
    } frame_t;

    beat_t  beat_q[$];
    frame_t frame_q[$];
    beat_t  b_cur;
    frame_t hold;
    int     checks = 0;
    int     errors = 0;
    int     fcnt_model = 0;
    logic   rst_seen = 1'b0;
    logic   started = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_seen <= !rst_n;

    // Monitor: pops expected beats/frames whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_seen) begin
            chk("reset_uo_out", int'(uo_out), 0);
            chk("reset_uio_out", int'(uio_out), 0);
            chk("reset_uio_oe", int'(uio_oe), 255);
            hold    = '0;
            started = 1'b1;
        end else if (started) begin
            if (uo_out[2]) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: valid_out=1, expected no pending beat");
                end else begin
                    b_cur = beat_q.pop_front();
                    chk("diff", int'(uo_out[0]), int'(b_cur.d));
                    chk("last_out", int'(uo_out[3]), int'(b_cur.last));
                    if (b_cur.last) begin
                        if (frame_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL missing_frame: frame end seen with no expected frame");
                        end else begin
                            hold = frame_q.pop_front();
                            $display("frame end: exp res=%02h flag=%0b zero=%0b ovf=%0b cnt=%0d | got uo_out=%02h uio_out=%02h",
                                     hold.res, hold.flag, hold.zero, hold.ovf, hold.fcnt, uo_out, uio_out);
                        end
                    end
                end
            end else begin
                chk("idle_diff", int'(uo_out[0]), 0);
                chk("idle_last", int'(uo_out[3]), 0);
            end
            chk("borrow_out", int'(uo_out[1]), int'(hold.flag));
            chk("zero", int'(uo_out[4]), int'(hold.zero));
            chk("ovf", int'(uo_out[5]), int'(hold.ovf));
            chk("frame_cnt", int'(uo_out[7:6]), int'(hold.fcnt));
            chk("uio_out", int'(uio_out), int'(hold.res));
            chk("uio_oe", int'(uio_oe), 255);
        end
    end

    task automatic drive(input logic a, input logic b, input logic v, input logic l,
                         input logic e, input logic m);
        @(posedge clk);
        #1;
        ui_in = {4'($urandom), l, v, b, a};
        ena   = e;
`ifdef SUB_ADD_MODE_EN
        uio_in = {7'($urandom), m};
`else
        uio_in = {7'($urandom), m ^ 1'($urandom)};
`endif
    endtask

    // Non-beat cycle: either valid low (last may be high) or valid high with the tile disabled.
    task automatic idle();
        if ($urandom_range(0, 1) == 1)
            drive(1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b1, 1'($urandom));
        else
            drive(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic send_frame(input int a, input int b, input int len, input int gmin,
                              input int gmax, input bit mode, input int stop_at);
        int     m;
        int     dv;
        int     n;
        bit     flag;
        frame_t f;
        m = (1 << len) - 1;
        a = a & m;
        b = b & m;
        if (mode) begin
            dv   = (a + b) & m;
            flag = ((a + b) >> len) != 0;
        end else begin
            dv   = (a - b) & m;
            flag = a < b;
        end
        n = (stop_at >= 0) ? stop_at : len;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmin, gmax)) idle();
            drive(1'((a >> i) & 1), 1'((b >> i) & 1), 1'b1, 1'(i == len - 1), 1'b1,
                  (i == 0) ? mode : 1'($urandom));
            beat_q.push_back('{d: 1'((dv >> i) & 1), last: 1'(i == len - 1)});
        end
        if (n == len) begin
            fcnt_model++;
            f.res  = 8'(dv);
            f.flag = flag;
            f.zero = ((dv & 8'hFF) == 0);
            f.ovf  = (len > 8);
            f.fcnt = 2'(fcnt_model);
            frame_q.push_back(f);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ui_in = 8'($urandom);
        ena   = 1'b1;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ui_in      = 8'h00;
        fcnt_model = 0;
    endtask

    initial begin
        bit mode;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_frame(5, 3, 4, 0, 0, 1'b0, -1);
        send_frame(3, 5, 4, 0, 0, 1'b0, -1);
        send_frame(8'hA5, 8'hA5, 8, 0, 0, 1'b0, -1);
        send_frame(5, 3, 4, 1, 3, 1'b0, -1);
        send_frame(9, 2, 4, 0, 1, 1'b0, 2);
        do_reset();
        send_frame(1, 1, 1, 0, 0, 1'b0, -1);
        send_frame(int'($urandom), int'($urandom), 10, 0, 1, 1'b0, -1);
`ifdef SUB_ADD_MODE_EN
        send_frame(8'h0F, 8'h01, 8, 0, 0, 1'b1, -1);
        send_frame(8'h0F, 8'h01, 8, 0, 0, 1'b0, -1);
`endif
        for (int k = 0; k < 40; k++) begin
`ifdef SUB_ADD_MODE_EN
            mode = 1'($urandom);
`else
            mode = 1'b0;
`endif
            send_frame(int'($urandom), int'($urandom), int'($urandom_range(1, 11)), 0,
                       int'($urandom_range(0, 2)), mode, -1);
        end
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("beat_q_drained", beat_q.size(), 0);
        chk("frame_q_drained", frame_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
